branch_predict_unit: RTL

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_pred_table.sv | 83 ++++++++
 rtl/branch_predict_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predict unit.
package branch_pkg;

    // 2-bit saturating direction counter
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } sat_cnt_e;

    localparam sat_cnt_e    CNT_RST = WNT;
    localparam logic [31:0] PC_INC  = 32'd4;

    // Next counter value for a resolved branch: a tag miss seeds a weak state,
    // a hit steps one state toward the outcome and saturates at the ends.
    function automatic sat_cnt_e cnt_next(input sat_cnt_e cur, input logic hit,
                                          input logic taken);
        sat_cnt_e nxt;
        if (!hit)
            nxt = taken ? WT : WNT;
        else if (taken)
            nxt = (cur == ST) ? ST : sat_cnt_e'(cur + 2'd1);
        else
            nxt = (cur == SNT) ? SNT : sat_cnt_e'(cur - 2'd1);
        return nxt;
    endfunction

endpackage

// File: rtl/branch_pred_table.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Asynchronous read port for fetch, one write port for execute-stage resolves.
// A same-cycle read of the entry being written returns the old contents.
module branch_pred_table
    import branch_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  rd_pc,
    output logic             rd_taken,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic [PC_W-1:0]  wr_pc,
    input  logic             wr_taken,
    input  logic [31:0]      wr_target
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [31:0]      tgt_q [DEPTH];
    logic [31:0]      tgt_d [DEPTH];
    sat_cnt_e         cnt_q [DEPTH];
    sat_cnt_e         cnt_d [DEPTH];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_hit;

    // Word-aligned PCs: the two low bits never select an entry
    logic unused_lsb;
    assign unused_lsb = ^{rd_pc[1:0], wr_pc[1:0]};

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[PC_W-1:IDX_W+2];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[PC_W-1:IDX_W+2];

    // Asynchronous lookup; forced low while reset is held
    assign rd_taken  = ~reset & valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag)
                     & (cnt_q[rd_idx] >= WT);
    assign rd_target = rd_taken ? tgt_q[rd_idx] : 32'd0;

    assign wr_hit = valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);

    // Next-state for the written entry; all others hold
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            tgt_d[wr_idx]   = wr_target;
            cnt_d[wr_idx]   = cnt_next(cnt_q[wr_idx], wr_hit, wr_taken);
        end
    end

    // Table storage; reset discards any write in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= CNT_RST;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolve / redirect logic with performance counters.
// Define BRANCH_BTB_EN to add the dynamic predictor (branch_pred_table);
// without it fetch always predicts not-taken and every taken branch redirects.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic             ex_jalr,
    input  logic [31:0]      ex_rs1,
    input  logic             ex_cond,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic             halt,
    output logic [31:0]      pc_four,
    output logic [31:0]      br_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic [31:0]      pc_full;
    logic             resolve, actual_taken;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    assign pc_full      = 32'(ex_pc);
    assign pc_four      = halt ? 32'd0 : pc_full + PC_INC;
    assign br_target    = ex_jalr ? ex_rs1 + ex_imm : pc_full + ex_imm;
    assign resolve      = ex_valid & (ex_branch | ex_jump);
    assign actual_taken = (ex_branch & ex_cond) | ex_jump;

`ifdef BRANCH_BTB_EN
    // Mispredict on wrong direction, or right direction but wrong target
    assign redirect = resolve & ((actual_taken != ex_pred_taken)
                    | (actual_taken & (ex_pred_target != br_target)));

    branch_pred_table #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .rd_pc     (if_pc),
        .rd_taken  (pred_taken),
        .rd_target (pred_target),
        .wr_en     (resolve),
        .wr_pc     (ex_pc),
        .wr_taken  (actual_taken),
        .wr_target (br_target)
    );
`else
    // Static not-taken: the carried prediction is always not-taken
    logic unused_pred;
    assign unused_pred = ^{if_pc, ex_pred_taken, ex_pred_target};
    assign redirect    = resolve & actual_taken;
    assign pred_taken  = 1'b0;
    assign pred_target = 32'd0;
`endif

    assign redirect_pc = !redirect ? 32'd0 : (actual_taken ? br_target : pc_four);

    // Counter next-state: one per resolve, one per redirect, free wrap
    always_comb begin
        branch_cnt_d  = branch_cnt_q + CNT_W'(resolve);
        mispred_cnt_d = mispred_cnt_q + CNT_W'(redirect);
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
